// File: rtl/vga_scan_controller.sv
// Raster timing master: scans (x, y), delays sync/blank to match the pixel-source latency.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_pattern input (x ^ y gray ramp).
module vga_scan_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_LATENCY = 1,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  output logic [9:0]        x,
  output logic [9:0]        y,
  input  logic [DATA_W-1:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [DATA_W-1:0] vga_gray,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_scan_controller: H_TOTAL/V_TOTAL exceed the 10-bit counters");
  end
  if (PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_latency
    $error("vga_scan_controller: PIX_LATENCY must be 1..4");
  end

  logic [9:0]        h_cnt_r, v_cnt_r;
  logic              frame_start_r;
  logic              active_s, hs_raw_s, vs_raw_s;
  logic              act_d_s, hs_d_s, vs_d_s;
  logic [DATA_W-1:0] gray_next_s;

  // Raster counters and the coordinate-side frame marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r       <= 10'd0;
      v_cnt_r       <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_en && (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
      if (pix_en) begin
        if (h_cnt_r == H_LAST) begin
          h_cnt_r <= 10'd0;
          v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
        end else begin
          h_cnt_r <= h_cnt_r + 10'd1;
        end
      end
    end
  end

  assign active_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  assign hs_raw_s = ~((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
  assign vs_raw_s = ~((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] pat_raw_s, pat_d_s;
  assign pat_raw_s = h_cnt_r[7:0] ^ v_cnt_r[7:0];
`endif

  // The output register is the last alignment stage, so only PIX_LATENCY-1 stages live here
  if (PIX_LATENCY == 1) begin : g_no_dly
    assign act_d_s = active_s;
    assign hs_d_s  = hs_raw_s;
    assign vs_d_s  = vs_raw_s;
`ifdef VGA_TEST_PATTERN_EN
    assign pat_d_s = pat_raw_s;
`endif
  end else begin : g_dly
    logic [PIX_LATENCY-2:0] act_sr_r, hs_sr_r, vs_sr_r;
`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] pat_sr_r [PIX_LATENCY-1];
`endif

    // Alignment shift register, advancing on pixel ticks only
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        act_sr_r <= {(PIX_LATENCY-1){1'b0}};
        hs_sr_r  <= {(PIX_LATENCY-1){1'b1}};
        vs_sr_r  <= {(PIX_LATENCY-1){1'b1}};
`ifdef VGA_TEST_PATTERN_EN
        for (int i = 0; i < PIX_LATENCY-1; i++) pat_sr_r[i] <= 8'h00;
`endif
      end else if (pix_en) begin
        act_sr_r[0] <= active_s;
        hs_sr_r[0]  <= hs_raw_s;
        vs_sr_r[0]  <= vs_raw_s;
        for (int i = 1; i < PIX_LATENCY-1; i++) begin
          act_sr_r[i] <= act_sr_r[i-1];
          hs_sr_r[i]  <= hs_sr_r[i-1];
          vs_sr_r[i]  <= vs_sr_r[i-1];
        end
`ifdef VGA_TEST_PATTERN_EN
        pat_sr_r[0] <= pat_raw_s;
        for (int i = 1; i < PIX_LATENCY-1; i++) pat_sr_r[i] <= pat_sr_r[i-1];
`endif
      end
    end

    assign act_d_s = act_sr_r[PIX_LATENCY-2];
    assign hs_d_s  = hs_sr_r[PIX_LATENCY-2];
    assign vs_d_s  = vs_sr_r[PIX_LATENCY-2];
`ifdef VGA_TEST_PATTERN_EN
    assign pat_d_s = pat_sr_r[PIX_LATENCY-2];
`endif
  end

  // Blanked pixels are forced to zero
  always_comb begin
    gray_next_s = {DATA_W{1'b0}};
    if (act_d_s) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_pattern) begin
        gray_next_s = DATA_W'(pat_d_s);
      end else begin
        gray_next_s = pix_data;
      end
`else
      gray_next_s = pix_data;
`endif
    end else begin
      gray_next_s = {DATA_W{1'b0}};
    end
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      blank_n  <= 1'b0;
      vga_gray <= {DATA_W{1'b0}};
    end else if (pix_en) begin
      hsync    <= hs_d_s;
      vsync    <= vs_d_s;
      blank_n  <= act_d_s;
      vga_gray <= gray_next_s;
    end
  end

  assign x           = h_cnt_r;
  assign y           = v_cnt_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: full-size 640x480 instance (latency 1) plus a 16x8 raster instance (latency 3).
module tb_vga_scan_controller;

  logic       clk, reset, pix_en;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [7:0] pix_data_d, pix_data_s, gray_d, gray_s;
  logic       hs_d, vs_d, bl_d, fs_d;
  logic       hs_s, vs_s, bl_s, fs_s;
  logic [7:0] src0, src1;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_pattern;
`endif

  int vectors = 0;
  int miscompares = 0;

  vga_scan_controller #(.PIX_LATENCY(1)) dut_d (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x_d), .y(y_d),
    .pix_data(pix_data_d),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .vga_gray(gray_d), .hsync(hs_d), .vsync(vs_d), .blank_n(bl_d), .frame_start(fs_d)
  );

  vga_scan_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_LATENCY(3), .DATA_W(8)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x_s), .y(y_s),
    .pix_data(pix_data_s),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .vga_gray(gray_s), .hsync(hs_s), .vsync(vs_s), .blank_n(bl_s), .frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel source model: {y[1:0], x[5:0]} with two pipeline stages (total latency 3 ticks)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      src0 <= 8'h00;
      src1 <= 8'h00;
    end else if (pix_en) begin
      src0 <= {y_s[1:0], x_s[5:0]};
      src1 <= src0;
    end
  end
  assign pix_data_s = src1;

  task automatic apply_reset();
    reset = 1'b1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pix_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({x_d, y_d, hs_d, vs_d, bl_d, gray_d, fs_d} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_big: got x=%0d y=%0d hs=%b vs=%b bl=%b g=%h fs=%b, want 0 0 1 1 0 00 0",
               x_d, y_d, hs_d, vs_d, bl_d, gray_d, fs_d);
    end
    vectors++;
    if ({x_s, y_s, hs_s, vs_s, bl_s, gray_s, fs_s} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_small: got x=%0d y=%0d hs=%b vs=%b bl=%b g=%h fs=%b, want 0 0 1 1 0 00 0",
               x_s, y_s, hs_s, vs_s, bl_s, gray_s, fs_s);
    end
  endtask

  task automatic test_hsync_timing();
    int fall1 = -1, rise1 = -1, fall2 = -1, bfall = -1;
    logic prev_hs = 1'b1, prev_bl = 1'b0;
    apply_reset();
    for (int k = 1; k <= 1500; k++) begin
      @(posedge clk); #1;
      if (prev_hs && !hs_d) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      if (!prev_hs && hs_d && rise1 < 0) rise1 = k;
      if (prev_bl && !bl_d && bfall < 0) bfall = k;
      prev_hs = hs_d;
      prev_bl = bl_d;
    end
    vectors++;
    if (fall1 !== 657) begin miscompares++; $display("FAIL hsync_first_fall: got %0d want 657", fall1); end
    vectors++;
    if (rise1 - fall1 !== 96) begin miscompares++; $display("FAIL hsync_width: got %0d want 96", rise1 - fall1); end
    vectors++;
    if (fall2 - fall1 !== 800) begin miscompares++; $display("FAIL hsync_period: got %0d want 800", fall2 - fall1); end
    vectors++;
    if (bfall !== 641) begin miscompares++; $display("FAIL blank_first_fall: got %0d want 641", bfall); end
    vectors++;
    if ({x_d, y_d} !== {10'd700, 10'd1}) begin
      miscompares++;
      $display("FAIL count_1500: got x=%0d y=%0d want 700 1", x_d, y_d);
    end
  endtask

  task automatic test_pix_en_gating();
    apply_reset();
    pix_data_d = 8'h3C;
    repeat (300) @(posedge clk);
    #1;
    vectors++;
    if ({x_d, bl_d, gray_d} !== {10'd300, 1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL gate_pre: got x=%0d bl=%b g=%h want 300 1 3c", x_d, bl_d, gray_d);
    end
    pix_en = 1'b0;
    pix_data_d = 8'hC3;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({x_d, y_d, hs_d, vs_d, bl_d, gray_d, fs_d, fs_s} !==
          {10'd300, 10'd0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL gate_hold[%0d]: got x=%0d y=%0d hs=%b vs=%b bl=%b g=%h fs=%b/%b", i,
                 x_d, y_d, hs_d, vs_d, bl_d, gray_d, fs_d, fs_s);
      end
    end
    pix_en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({x_d, gray_d} !== {10'd301, 8'hC3}) begin
      miscompares++;
      $display("FAIL gate_resume: got x=%0d g=%h want 301 c3", x_d, gray_d);
    end
    pix_data_d = 8'h3C;
  endtask

  task automatic test_frame_period();
    int p1 = -1, p2 = -1, nfs = 0, vlow = 0, vfall = -1;
    logic prev_vs = 1'b1;
    apply_reset();
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (fs_s) begin
        nfs++;
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
      if (k <= 128 && !vs_s) vlow++;
      if (prev_vs && !vs_s && vfall < 0) vfall = k;
      prev_vs = vs_s;
    end
    vectors++;
    if ({p1, p2, nfs} !== {32'd128, 32'd256, 32'd2}) begin
      miscompares++;
      $display("FAIL frame_period: got pulses at %0d,%0d count %0d want 128,256 count 2", p1, p2, nfs);
    end
    vectors++;
    if ({vfall, vlow} !== {32'd83, 32'd32}) begin
      miscompares++;
      $display("FAIL vsync_width: got fall %0d low %0d want 83 32", vfall, vlow);
    end
    p1 = -1; p2 = -1; nfs = 0;
    apply_reset();
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      if (fs_s) begin
        nfs++;
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
      pix_en = ((k % 2) == 0);
    end
    pix_en = 1'b1;
    vectors++;
    if ({p1, p2, nfs} !== {32'd255, 32'd511, 32'd2}) begin
      miscompares++;
      $display("FAIL frame_period_half: got pulses at %0d,%0d count %0d want 255,511 count 2", p1, p2, nfs);
    end
  endtask

  task automatic test_alignment();
    int c, cx, cy;
    logic       e_bl, e_hs, e_vs;
    logic [7:0] e_g;
    apply_reset();
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        e_bl = 1'b0; e_g = 8'h00; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        c  = (k - 3) % 128;
        cx = c % 16;
        cy = c / 16;
        e_bl = (cx < 8) && (cy < 4);
        e_g  = e_bl ? {cy[1:0], cx[5:0]} : 8'h00;
        e_hs = !(cx >= 10 && cx <= 12);
        e_vs = !(cy == 5 || cy == 6);
      end
      vectors++;
      if ({bl_s, gray_s, hs_s, vs_s, x_s, y_s} !== {e_bl, e_g, e_hs, e_vs, 10'(k % 16), 10'((k / 16) % 8)}) begin
        miscompares++;
        $display("FAIL align[%0d]: got bl=%b g=%h hs=%b vs=%b x=%0d y=%0d want bl=%b g=%h hs=%b vs=%b x=%0d y=%0d",
                 k, bl_s, gray_s, hs_s, vs_s, x_s, y_s, e_bl, e_g, e_hs, e_vs, k % 16, (k / 16) % 8);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int f_s = -1, f_d = -1;
    logic p_s = 1'b1, p_d = 1'b1;
    apply_reset();
    repeat (94) @(posedge clk);
    #1;
    vectors++;
    if ({x_s, y_s, hs_s, vs_s} !== {10'd14, 10'd5, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midframe_pre: got x=%0d y=%0d hs=%b vs=%b want 14 5 0 0", x_s, y_s, hs_s, vs_s);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({x_s, y_s, hs_s, vs_s, bl_s, gray_s, fs_s} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL midframe_async: got x=%0d y=%0d hs=%b vs=%b bl=%b g=%h fs=%b want 0 0 1 1 0 00 0",
               x_s, y_s, hs_s, vs_s, bl_s, gray_s, fs_s);
    end
    vectors++;
    if ({x_d, y_d, hs_d, bl_d, gray_d} !== {10'd0, 10'd0, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL midframe_async_big: got x=%0d y=%0d hs=%b bl=%b g=%h want 0 0 1 0 00",
               x_d, y_d, hs_d, bl_d, gray_d);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (p_s && !hs_s && f_s < 0) f_s = k;
      if (p_d && !hs_d && f_d < 0) f_d = k;
      p_s = hs_s;
      p_d = hs_d;
    end
    vectors++;
    if ({f_s, f_d} !== {32'd13, 32'd657}) begin
      miscompares++;
      $display("FAIL midframe_resume: got hsync falls %0d/%0d want 13/657", f_s, f_d);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern_mode();
    apply_reset();
    test_pattern = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 21) begin
        vectors++;
        if (gray_s !== 8'h03) begin miscompares++; $display("FAIL pattern_2_1: got %h want 03", gray_s); end
      end
      if (k == 56) begin
        vectors++;
        if (gray_s !== 8'h06) begin miscompares++; $display("FAIL pattern_5_3: got %h want 06", gray_s); end
      end
    end
    test_pattern = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    pix_data_d = 8'h3C;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    test_reset();
    test_hsync_timing();
    test_pix_en_gating();
    test_frame_period();
    test_alignment();
    test_reset_mid_frame();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Raster timing master for the VGA output path; drives the pixel coordinate bus (x, y) consumed by the image filter stage.
- Captures the returned pixel data and emits it with hsync/vsync/blank_n, delayed so that data and sync stay aligned across the pixel-source pipeline latency.
- Default timing is 640x480@60 at a 25 MHz pixel rate, derived from a pixel-enable tick on the system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LATENCY, 1, pixel-source latency in pix_en ticks; legal range 1..4
- DATA_W, 8, pixel data width

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel tick; all state advances only on clk edges where pix_en=1
- x  out  10  current horizontal count (h_cnt)
- y  out  10  current vertical count (v_cnt)
- pix_data  in  DATA_W  pixel value returned by the source for the coordinate issued PIX_LATENCY ticks earlier
- vga_gray  out  DATA_W  output pixel; 0 when blanked
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  1 during the visible region, aligned with vga_gray
- frame_start  out  1  single-clk pulse marking the start of a frame
- test_pattern  in  1  present only with VGA_TEST_PATTERN_EN; see Optional Feature

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async, any time, including mid-frame):
  - h_cnt = v_cnt = 0, so x = y = 0.
  - hsync = vsync = 1; blank_n = 0; vga_gray = 0; frame_start = 0.
  - All delay-line stages are cleared to the inactive state: sync = 1, active = 0.
- Counter advance, on each tick with pix_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - x and y are the registered counters, updated in the same edge.
- pix_en=0: every register holds, outputs included; frame_start is 0.
- Raw decode, from the current counts:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw = 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment:
  - active, hs_raw and vs_raw enter a PIX_LATENCY-deep shift register that advances on pix_en.
  - The output registers update on pix_en ticks only:
    - hsync and vsync take the delayed sync values.
    - blank_n takes the delayed active.
    - vga_gray = pix_data when the delayed active is 1, else 0.
  - Net effect: the coordinate issued at tick n appears on all outputs after the tick n+PIX_LATENCY edge.
- pix_data is sampled only on pix_en ticks. The source must hold it stable between ticks.
- frame_start:
  - Asserted for exactly one clk, on the pix_en edge where the counts wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Not delayed by PIX_LATENCY; it marks the coordinate-side frame start.
  - Not asserted on reset release.
- First frame after reset: the counters start at (0,0) with no frame_start pulse for that frame.
- Width rule: counters are 10 bits. H_TOTAL and V_TOTAL must be <= 1024 (checked by an elaboration-time assertion).

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - The test_pattern input port exists.
  - When test_pattern=1, the active-region output value is x_d[7:0] ^ y_d[7:0], where x_d and y_d are the coordinates delayed by PIX_LATENCY.
  - This value is zero-extended or truncated to DATA_W. pix_data is ignored.
  - test_pattern is sampled on pix_en ticks; changes take effect on the next tick.
  - Sync and blank timing are unchanged.
- Undefined: no test_pattern port; vga_gray always follows pix_data when active.

Test Plan:
- Reset, then pix_en=1 continuously, PIX_LATENCY=1:
  - The first hsync fall occurs after edge 657 (coordinate 656 plus 1 tick).
  - hsync stays low for exactly 96 clks and repeats every 800 clks.
- Frame period:
  - Count clks between consecutive frame_start pulses: exactly 420000 with pix_en=1, 840000 with pix_en toggling every other clk.
  - vsync is low for exactly 1600 clks (2 lines) when pix_en=1.
- Data alignment, PIX_LATENCY=3:
  - A model source returns {y[1:0], x[5:0]} delayed 3 ticks.
  - vga_gray matches that value for every active pixel; it is 0 at h_cnt 640..799 and on lines 480..524; blank_n toggles in the same edge.
- pix_en gating: hold pix_en=0 for 50 clks mid-line at x=300 -> x, y and all outputs are frozen and no frame_start occurs; counting resumes at 301.
- Reset mid-frame:
  - Assert reset at x=700, y=490, with hsync and vsync low -> on the same edge without a clk, hsync=vsync=1, blank_n=0, vga_gray=0, x=y=0.
  - After release, the next hsync fall again occurs at coordinate 656.
- VGA_TEST_PATTERN_EN defined, test_pattern=1 -> at (x=5, y=3), vga_gray=0x06 after PIX_LATENCY ticks, and pix_data is ignored.
